bus_interconnect: RTL

Parametrised single-master, N-slave memory-mapped interconnect between Core and SoC peripherals. It generalises the fixed bit-31 memory/LED split to NUM_SLAVES address windows set by base/mask parameters. It latches each request, holds the selected slave's strobe until that slave acks, and returns one ack per transaction. Unmapped addresses, illegal requests and slave timeouts get an error response, so the core never hangs.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_addr_decoder.sv | 43 ++++
 rtl/bus_interconnect.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the single-master memory-mapped interconnect:
//   - bus_state_e : transaction FSM encoding (IDLE / ACCESS / RESPOND)
//   - DATA_W, ADDR_W : bus data and address widths
//   - DEFAULT_ERROR_DATA : read data returned alongside an error response
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [DATA_W-1:0] DEFAULT_ERROR_DATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_addr_decoder.sv
// -----------------------------------------------------------------------------
// bus_addr_decoder
// Combinational address decoder over NUM_SLAVES base/mask windows.
// Slot i hits when (addr & mask_i) == base_i. Overlapping windows are legal;
// the lowest-index hit is reported on idx.
//
// Ports:
//   addr    in   ADDR_W      address to decode
//   hit_vec out  NUM_SLAVES  raw per-window hit flags (may have several bits)
//   idx     out  IDX_W       index of the lowest-numbered hit (0 when no hit)
//   hit     out  1           at least one window matched
// -----------------------------------------------------------------------------
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] hit_vec,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit
);

  always_comb begin
    hit_vec = '0;
    idx     = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_vec[i] = ((addr & SLAVE_MASK[ADDR_W*i +: ADDR_W]) == SLAVE_BASE[ADDR_W*i +: ADDR_W]);
    end
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// -----------------------------------------------------------------------------
// bus_interconnect
// Single-master, NUM_SLAVES-slave memory-mapped interconnect. A master request
// is latched in IDLE, decoded to a slot and forwarded as a held strobe until
// that slot acks (ACCESS). One ack_o pulse per transaction is returned in
// RESPOND. Unmapped addresses, rd+wr together and slave timeouts complete with
// err_o so the master never stalls forever.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rd_en_i, wr_en_i master read / write request levels (held until ack_o)
//   byte_enable_i    master byte lanes
//   addr_i, data_i   master address / write data
//   data_o           read data (holds until the next response)
//   ack_o, err_o     one-cycle completion pulse and its error qualifier
//   s_rd_en_o        per-slave read strobe
//   s_wr_en_o        per-slave write strobe
//   s_addr_o, s_data_o, s_byte_enable_o  latched request, shared by all slaves
//   s_data_i         flattened per-slave read data (slot i at [32*i +: 32])
//   s_ack_i          per-slave ack
// -----------------------------------------------------------------------------
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {32'h8000_2000, 32'h8000_1000,
                                                            32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {32'hFFFF_F000, 32'hFFFF_F000,
                                                            32'hFFFF_F000, 32'h8000_0000},
  parameter int                           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]            ERROR_DATA     = DEFAULT_ERROR_DATA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en_i,
  input  logic                         wr_en_i,
  input  logic [3:0]                   byte_enable_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         ack_o,
  output logic                         err_o,
  output logic [NUM_SLAVES-1:0]        s_rd_en_o,
  output logic [NUM_SLAVES-1:0]        s_wr_en_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_data_o,
  output logic [3:0]                   s_byte_enable_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);

  localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter holds the number of ACCESS cycles already completed, so the
  // last permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  bus_state_e            state_q, state_d;

  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [3:0]            be_q;
  logic [IDX_W-1:0]      sel_q;
  logic [NUM_SLAVES-1:0] sel_oh_q;
  logic                  is_wr_q;
  logic                  err_q;
  logic [TO_W-1:0]       to_cnt_q;

  logic [NUM_SLAVES-1:0] dec_hit_vec;
  logic [NUM_SLAVES-1:0] dec_first_oh;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;

  logic                  req;
  logic                  req_ok;
  logic                  sel_ack;
  logic                  timeout_hit;
  logic [DATA_W-1:0]     slave_rdata;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr    (addr_i),
    .hit_vec (dec_hit_vec),
    .idx     (dec_idx),
    .hit     (dec_hit)
  );

  // Isolate the lowest set hit bit so the one-hot select agrees with dec_idx
  // when windows overlap.
  assign dec_first_oh = dec_hit_vec & ~(dec_hit_vec - NUM_SLAVES'(1));

  assign req         = rd_en_i | wr_en_i;
  assign req_ok      = dec_hit & (rd_en_i ^ wr_en_i);
  assign sel_ack     = |(s_ack_i & sel_oh_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_W'(TO_LAST));

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) begin
        slave_rdata = s_data_i[DATA_W*i +: DATA_W];
      end
    end
  end

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM next state and control outputs ----
  always_comb begin
    state_d   = state_q;
    s_rd_en_o = '0;
    s_wr_en_o = '0;
    ack_o     = 1'b0;
    err_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = req_ok ? ACCESS : RESPOND;
        end
      end
      ACCESS: begin
        if (is_wr_q) begin
          s_wr_en_o = sel_oh_q;
        end else begin
          s_rd_en_o = sel_oh_q;
        end
        // An ack coinciding with the timeout still leaves via RESPOND; the
        // datapath below gives the ack priority for the error flag.
        if (sel_ack || timeout_hit) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        ack_o   = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- Request latch, response capture and timeout counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      sel_q    <= '0;
      sel_oh_q <= '0;
      is_wr_q  <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
      data_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (req) begin
            addr_q   <= addr_i;
            wdata_q  <= data_i;
            be_q     <= byte_enable_i;
            sel_q    <= dec_idx;
            sel_oh_q <= dec_first_oh;
            is_wr_q  <= wr_en_i;
            err_q    <= ~req_ok;
            if (!req_ok) begin
              data_o <= ERROR_DATA;
            end
          end
        end
        ACCESS: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (sel_ack) begin
            err_q  <= 1'b0;
            data_o <= is_wr_q ? '0 : slave_rdata;
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            data_o <= ERROR_DATA;
          end
        end
        RESPOND: begin
          to_cnt_q <= '0;
        end
        default: begin
          to_cnt_q <= '0;
        end
      endcase
    end
  end

  assign s_addr_o        = addr_q;
  assign s_data_o        = wdata_q;
  assign s_byte_enable_o = be_q;

endmodule
